// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes I/S/B/U/J/Z immediates to XLEN bits and
// carries them through STAGES valid/ready register slices with backpressure and flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned STAGES   = 2,
    parameter bit          AUTO_SEL = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [2:0]      i_imm_sel,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_sel,
    output logic            o_err
);

    localparam logic [2:0] SelI   = 3'd0;
    localparam logic [2:0] SelS   = 3'd1;
    localparam logic [2:0] SelB   = 3'd2;
    localparam logic [2:0] SelU   = 3'd3;
    localparam logic [2:0] SelJ   = 3'd4;
    localparam logic [2:0] SelZ   = 3'd5;
    localparam logic [2:0] SelBad = 3'd7;

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic [2:0]      auto_sel;
    logic [2:0]      dec_sel;
    logic            dec_err;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    // Opcode-based format decode, only selected when AUTO_SEL is set.
    always_comb begin
        auto_sel = SelBad;
        case (i_inst[6:0])
            OpImm, OpLoad, OpJalr: auto_sel = SelI;
            OpSystem:              auto_sel = i_inst[14] ? SelZ : SelI;
            OpStore:               auto_sel = SelS;
            OpBranch:              auto_sel = SelB;
            OpLui, OpAuipc:        auto_sel = SelU;
            OpJal:                 auto_sel = SelJ;
            default:               auto_sel = SelBad;
        endcase
    end

    always_comb begin
        dec_sel = AUTO_SEL ? auto_sel : i_imm_sel;
        dec_err = 1'b0;
        imm32   = '0;
        case (dec_sel)
            SelI: imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            SelS: imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            SelB: imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
            SelU: imm32 = {i_inst[31:12], 12'b0};
            SelJ: imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                           i_inst[30:21], 1'b0};
            SelZ: imm32 = {27'b0, i_inst[19:15]};
            default: dec_err = 1'b1;
        endcase
    end

    // Every 32-bit form is already sign-correct at bit 31 (Z and reserved have it clear).
    if (XLEN == 64) begin : g_xlen64
        assign dec_imm = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
        assign dec_imm = imm32;
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] in_v;
    logic [XLEN-1:0]   in_imm [STAGES];
    logic [2:0]        in_sel [STAGES];
    logic              in_err [STAGES];
    logic [XLEN-1:0]   imm_q  [STAGES];
    logic [2:0]        sel_q  [STAGES];
    logic              err_q  [STAGES];

    // Stage k can load if downstream is ready or any stage from k to the output is empty;
    // this is the unrolled form of the ready chain, so there is no bubble.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        assign load[k] = i_ready | ~(&v_q[STAGES-1:k]);
    end

    always_comb begin
        in_v[0]   = i_valid;
        in_imm[0] = dec_imm;
        in_sel[0] = dec_sel;
        in_err[0] = dec_err;
        for (int k = 1; k < STAGES; k++) begin
            in_v[k]   = v_q[k-1];
            in_imm[k] = imm_q[k-1];
            in_sel[k] = sel_q[k-1];
            in_err[k] = err_q[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
                sel_q[k] <= '0;
                err_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (i_flush) begin
                    v_q[k] <= 1'b0;
                end else if (load[k]) begin
                    v_q[k] <= in_v[k];
                end
                // Data only moves with a real entry; flushed data is harmless.
                if (load[k] && in_v[k]) begin
                    imm_q[k] <= in_imm[k];
                    sel_q[k] <= in_sel[k];
                    err_q[k] <= in_err[k];
                end
            end
        end
    end

    assign o_ready = load[0];
    assign o_valid = v_q[STAGES-1];
    assign o_imm   = imm_q[STAGES-1];
    assign o_sel   = sel_q[STAGES-1];
    assign o_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32 external sel, XLEN32 auto sel, XLEN64)
// share stimulus; an arithmetic model and queue predict every output cycle.
module tb_imm_gen_pipe;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        rdy;
    logic [31:0] inst;
    logic [2:0]  sel;

    logic        ready_p, valid_p, err_p;
    logic [31:0] imm_p;
    logic [2:0]  sel_p;
    logic        ready_a, valid_a, err_a;
    logic [31:0] imm_a;
    logic [2:0]  sel_a;
    logic        ready_w, valid_w, err_w;
    logic [63:0] imm_w;
    logic [2:0]  sel_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_gen_pipe #(.XLEN(32), .STAGES(STAGES), .AUTO_SEL(1'b0)) dut_p (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(ready_p),
        .i_inst(inst), .i_imm_sel(sel), .o_valid(valid_p), .i_ready(rdy), .o_imm(imm_p),
        .o_sel(sel_p), .o_err(err_p)
    );

    imm_gen_pipe #(.XLEN(32), .STAGES(STAGES), .AUTO_SEL(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(ready_a),
        .i_inst(inst), .i_imm_sel(sel), .o_valid(valid_a), .i_ready(rdy), .o_imm(imm_a),
        .o_sel(sel_a), .o_err(err_a)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(STAGES), .AUTO_SEL(1'b0)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid), .o_ready(ready_w),
        .i_inst(inst), .i_imm_sel(sel), .o_valid(valid_w), .i_ready(rdy), .o_imm(imm_w),
        .o_sel(sel_w), .o_err(err_w)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Immediate value as a signed sum of weighted instruction fields.
    function automatic logic [63:0] model_imm(input logic [31:0] in, input logic [2:0] s);
        longint v;
        case (s)
            3'd0: v = longint'(in[30:20]) - longint'(in[31]) * 2048;
            3'd1: v = longint'(in[11:7]) + longint'(in[30:25]) * 32 - longint'(in[31]) * 2048;
            3'd2: v = longint'(in[11:8]) * 2 + longint'(in[30:25]) * 32
                      + longint'(in[7]) * 2048 - longint'(in[31]) * 4096;
            3'd3: v = longint'(in[30:12]) * 4096 - longint'(in[31]) * 64'sd2147483648;
            3'd4: v = longint'(in[30:21]) * 2 + longint'(in[20]) * 2048
                      + longint'(in[19:12]) * 4096 - longint'(in[31]) * 1048576;
            3'd5: v = longint'(in[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] model_auto_sel(input logic [31:0] in);
        case (in[6:0])
            7'h13, 7'h03, 7'h67: return 3'd0;
            7'h73:               return in[14] ? 3'd5 : 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h37, 7'h17:        return 3'd3;
            7'h6F:               return 3'd4;
            default:             return 3'd7;
        endcase
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        int          t;
    } entry_t;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        err;
        logic [31:0] aimm;
        logic [2:0]  asel;
        logic        aerr;
        logic [63:0] wimm;
        int          cyc;
    } out_t;

    entry_t q[$];
    out_t   log_q[$];
    int     last_dep = -100;

    // Per-cycle compare: an entry is visible STAGES cycles after acceptance, but never
    // before the cycle following its predecessor's departure.
    always @(negedge clk) begin : cmp
        logic        exp_valid, exp_ready;
        int          vis;
        logic [63:0] m, ma;
        logic [2:0]  as;
        out_t        o;
        if (!rst_n) begin
            q.delete();
            check("rst_valid_p", 64'(valid_p), 64'd0);
            check("rst_valid_w", 64'(valid_w), 64'd0);
            check("rst_imm_w", imm_w, 64'd0);
        end else begin
            exp_valid = 1'b0;
            if (q.size() > 0) begin
                vis = q[0].t + STAGES;
                if (last_dep + 1 > vis) vis = last_dep + 1;
                exp_valid = (vis <= cyc);
            end
            exp_ready = (q.size() < STAGES) || rdy;
            check("valid_p", 64'(valid_p), 64'(exp_valid));
            check("valid_a", 64'(valid_a), 64'(exp_valid));
            check("valid_w", 64'(valid_w), 64'(exp_valid));
            check("ready_p", 64'(ready_p), 64'(exp_ready));
            check("ready_a", 64'(ready_a), 64'(exp_ready));
            check("ready_w", 64'(ready_w), 64'(exp_ready));
            if (exp_valid) begin
                m  = model_imm(q[0].inst, q[0].sel);
                as = model_auto_sel(q[0].inst);
                ma = model_imm(q[0].inst, as);
                check("imm_p", 64'(imm_p), {32'b0, m[31:0]});
                check("sel_p", 64'(sel_p), 64'(q[0].sel));
                check("err_p", 64'(err_p), 64'(q[0].sel[2] & q[0].sel[1]));
                check("imm_w", imm_w, m);
                check("sel_w", 64'(sel_w), 64'(q[0].sel));
                check("imm_a", 64'(imm_a), {32'b0, ma[31:0]});
                check("sel_a", 64'(sel_a), 64'(as));
                check("err_a", 64'(err_a), 64'(as == 3'd7));
                if (rdy) begin
                    o = '{imm_p, sel_p, err_p, imm_a, sel_a, err_a, imm_w, cyc};
                    log_q.push_back(o);
                    void'(q.pop_front());
                    last_dep = cyc;
                end
            end
            if (flush) q.delete();
            else if (valid && exp_ready) q.push_back('{inst, sel, cyc});
        end
    end

    task automatic drive(input logic v, input logic [31:0] in, input logic [2:0] s,
                         input logic r, input logic f);
        @(posedge clk);
        #1;
        valid = v;
        inst  = in;
        sel   = s;
        rdy   = r;
        flush = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b, c_in;
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        rdy   = 1'b1;
        inst  = '0;
        sel   = '0;
        #3;
        check("reset_valid", 64'(valid_p), 64'd0);
        check("reset_imm", 64'(imm_p), 64'd0);
        check("reset_sel", 64'(sel_p), 64'd0);
        check("reset_err", 64'(err_p), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // addi x1,x0,-1: latency and sign extension
        b = log_q.size();
        drive(1'b1, 32'hFFF00093, 3'd0, 1'b1, 1'b0);
        c_in = cyc;
        idle(4);
        check("t1_count", 64'(log_q.size()), 64'(b + 1));
        check("t1_imm", 64'(log_q[b].imm), 64'hFFFF_FFFF);
        check("t1_imm64", log_q[b].wimm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_sel", 64'(log_q[b].sel), 64'd0);
        check("t1_err", 64'(log_q[b].err), 64'd0);
        check("t1_latency", 64'(log_q[b].cyc - c_in), 64'd2);

        // beq -4 then csrrwi back-to-back
        b = log_q.size();
        drive(1'b1, 32'hFE000EE3, 3'd2, 1'b1, 1'b0);
        drive(1'b1, 32'h3401D073, 3'd5, 1'b1, 1'b0);
        idle(4);
        check("t2_count", 64'(log_q.size()), 64'(b + 2));
        check("t2_imm0", 64'(log_q[b].imm), 64'hFFFF_FFFC);
        check("t2_imm1", 64'(log_q[b+1].imm), 64'h0000_0003);
        check("t2_asel1", 64'(log_q[b+1].asel), 64'd5);
        check("t2_consec", 64'(log_q[b+1].cyc - log_q[b].cyc), 64'd1);

        // backpressure: two accepted, third stalls until i_ready rises
        b = log_q.size();
        drive(1'b1, 32'h00500113, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h00112223, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h12345037, 3'd3, 1'b0, 1'b0);
        #2;
        check("t3_ready_full", 64'(ready_p), 64'd0);
        check("t3_valid_held", 64'(valid_p), 64'd1);
        drive(1'b1, 32'h12345037, 3'd3, 1'b0, 1'b0);
        #2;
        check("t3_imm_stable", 64'(imm_p), 64'd5);
        drive(1'b1, 32'h12345037, 3'd3, 1'b1, 1'b0);
        #2;
        check("t3_ready_rise", 64'(ready_p), 64'd1);
        idle(4);
        check("t3_count", 64'(log_q.size()), 64'(b + 3));
        check("t3_imm0", 64'(log_q[b].imm), 64'd5);
        check("t3_imm1", 64'(log_q[b+1].imm), 64'd4);
        check("t3_imm2", 64'(log_q[b+2].imm), 64'h1234_5000);

        // flush with one entry in flight and a simultaneous input transfer
        b = log_q.size();
        drive(1'b1, 32'h00700193, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 32'h00800213, 3'd0, 1'b1, 1'b1);
        idle(4);
        check("t4_flushed", 64'(log_q.size()), 64'(b));
        drive(1'b1, 32'hFFC00293, 3'd0, 1'b1, 1'b0);
        c_in = cyc;
        idle(4);
        check("t4_count", 64'(log_q.size()), 64'(b + 1));
        check("t4_imm", 64'(log_q[b].imm), 64'hFFFF_FFFC);
        check("t4_latency", 64'(log_q[b].cyc - c_in), 64'd2);

        // reserved sel, auto-decoded jal and unknown opcode
        b = log_q.size();
        drive(1'b1, 32'h0080006F, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 32'h0000007F, 3'd0, 1'b1, 1'b0);
        idle(4);
        check("t5_rsv_imm", 64'(log_q[b].imm), 64'd0);
        check("t5_rsv_err", 64'(log_q[b].err), 64'd1);
        check("t5_jal_imm", 64'(log_q[b].aimm), 64'd8);
        check("t5_jal_sel", 64'(log_q[b].asel), 64'd4);
        check("t5_bad_err", 64'(log_q[b+1].aerr), 64'd1);
        check("t5_bad_sel", 64'(log_q[b+1].asel), 64'd7);

        // 64-bit lui sign extension
        b = log_q.size();
        drive(1'b1, 32'h800000B7, 3'd3, 1'b1, 1'b0);
        idle(4);
        check("t6_imm64", log_q[b].wimm, 64'hFFFF_FFFF_8000_0000);
        check("t6_imm32", 64'(log_q[b].imm), 64'h8000_0000);

        // reset pulse mid-stream drops everything in flight
        b = log_q.size();
        drive(1'b1, 32'h00100093, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 32'h00200093, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 32'h00300093, 3'd0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(valid_w), 64'd0);
        check("t6_rst_imm", imm_w, 64'd0);
        check("t6_rst_imm32", 64'(imm_p), 64'd0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst_n = 1'b1;
        idle(5);
        check("t6_no_stale", 64'(log_q.size()), 64'(b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate generator. It extracts and sign-/zero-extends RISC-V immediates (I, S, B, U, J, CSR-Z) to XLEN bits, with format selection either external or decoded from the opcode. Transfers use a valid/ready handshake through STAGES register slices with full backpressure and flush, so the block can sit between fetch and execute in pipelined cores.

Parameters:
XLEN, 32, output width; legal values are 32 or 64.
STAGES, 2, number of register stages (1..4); sets latency.
AUTO_SEL, 0, 0 = format taken from i_imm_sel; 1 = format decoded from i_inst[6:0] and i_imm_sel is ignored.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_flush  in  1  discard all in-flight entries.
i_valid  in  1  input instruction valid.
o_ready  out  1  block can accept input this cycle.
i_inst  in  32  instruction word.
i_imm_sel  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (CSR zimm), 110/111 reserved.
o_valid  out  1  output entry valid.
i_ready  in  1  downstream accepts output.
o_imm  out  XLEN  extended immediate.
o_sel  out  3  format actually used (echo of i_imm_sel or auto-decoded value).
o_err  out  1  reserved sel, or unknown opcode when AUTO_SEL=1.

Behaviour:
- Reset (async, i_rst_n=0): all stage valid bits = 0, o_valid=0, o_imm=0, o_sel=0, o_err=0. o_ready=1 from the first cycle after release. Reset asserted mid-transfer drops every entry immediately; no output appears after release.
- Decode is combinational on input. The result {imm, sel, err} is captured in stage 0. Later stages only carry it. The output is driven from the last stage register.
- Field extraction (bit 0 of B and J is always 0):
  - I: inst[31:20].
  - S: inst[31:25], inst[11:7].
  - B: inst[31], inst[7], inst[30:25], inst[11:8], 0.
  - J: inst[31], inst[19:12], inst[20], inst[30:21], 0.
  - I/S/B/J are sign-extended from inst[31] to XLEN.
- U: {inst[31:12], 12'b0}. When XLEN=64, bits [63:32] are copies of inst[31].
- Z: inst[19:15] zero-extended.
- Reserved sel: imm = 0, err = 1.
- AUTO_SEL=1 opcode map:
  - 0010011, 0000011, 1100111 -> I.
  - 1110011 -> Z if inst[14]=1, else I.
  - 0100011 -> S. 1100011 -> B. 0110111, 0010111 -> U. 1101111 -> J.
  - Any other opcode -> sel=111, imm=0, err=1.
- Handshake: a transfer occurs on any edge where valid and ready are both 1.
  - Stage k loads when it is empty or stage k+1 (or downstream, for the last stage) takes its entry in the same cycle.
  - o_ready = !v[0] || stage 0 advancing. This is combinational through the chain and has no bubble.
  - Throughput is 1 per cycle. Latency is exactly STAGES cycles from input transfer to o_valid with i_ready held high.
- While o_valid=1 and i_ready=0, o_imm, o_sel and o_err hold stable. Entries are never dropped, duplicated or reordered.
- When all stages are full and i_ready=0, o_ready=0. If i_ready rises, o_ready=1 in the same cycle.
- Flush:
  - i_flush=1 clears all valid bits at the next edge.
  - It takes priority over a simultaneous input transfer; that instruction is discarded, although o_ready may read 1 that cycle.
  - o_valid=0 the cycle after. Data registers need not clear.
- Data registers load only on stage advance, which avoids needless toggling. Only the valid bits require reset; data is also reset for deterministic output.

Test Plan:
1. STAGES=2, i_inst=0xFFF00093 (addi x1,x0,-1), sel=000, i_ready=1 -> o_valid exactly 2 cycles after the transfer; o_imm=0xFFFFFFFF, o_sel=000, o_err=0.
2. Stream 0xFE000EE3 (beq -4, sel 010), then 0x3401D073 (csrrwi, sel 101) back-to-back -> outputs on consecutive cycles: 0xFFFFFFFC, then 0x00000003.
3. Backpressure, STAGES=2: 3 back-to-back inputs with i_ready=0 -> first 2 accepted, o_ready=0 on the 3rd, o_imm stable. Raise i_ready -> all 3 emerge in order, with no loss or duplicates.
4. i_flush=1 in the same cycle as an input transfer, with 1 entry in flight -> o_valid stays 0; the next instruction after the flush emerges normally after STAGES cycles.
5. sel=110 -> o_imm=0, o_err=1. With AUTO_SEL=1: i_inst=0x0080006F (jal x0,8) -> o_imm=8, o_sel=100; i_inst=0x0000007F -> o_err=1.
6. XLEN=64, i_inst=0x800000B7 (lui), sel=011 -> o_imm=0xFFFFFFFF80000000. Pulse i_rst_n low mid-stream -> o_valid=0 immediately, o_imm=0, and no stale output after release.
